hamming_pipe_decoder: RTL
=========================

Name: hamming_pipe_decoder

Overview:
- Parametrised, pipelined Hamming single-error-correcting decoder for the PUF response path.
- Default R=4 gives a (15,11) code; optional extended-parity bit gives SECDED.
- Valid/ready streaming replaces the level enable; two register stages.
- Saturating error counters feed PUF helper-data health monitoring.

Parameters:
- R, 4, number of Hamming parity bits (3..6); N = 2^R-1 codeword bits, K = N-R data bits (derived localparams).
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  codeword present on in_code
- in_ready  output  1  decoder accepts in_code this cycle
- in_code  input  CW  codeword; CW = N, or N+1 with SECDED_EN; bit i = code position i+1
- out_valid  output  1  out_data and flags valid
- out_ready  input  1  downstream accepts output
- out_data  output  K  corrected data
- out_syndrome  output  R  syndrome of this word
- out_corrected  output  1  single error corrected in this word
- out_uncorr  output  1  uncorrectable (double) error detected
- clr_cnt  input  1  synchronous clear of both counters
- corr_cnt  output  CNT_W  corrected-word count, saturating
- uncorr_cnt  output  CNT_W  uncorrectable-word count, saturating

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0, both stage valids=0. Reset mid-stream discards in-flight words; no partial output after release.
- Parity positions: i = 2^j-1, j=0..R-1. Syndrome bit j = XOR of in_code[i] over all i<N with bit j of (i+1) set.
- Data extraction: out_data[0] = lowest non-parity position (i=2), ascending. For R=4: i = 2,4,5,6,8..14.
- Stage 1 (S1): on accept, register codeword and syndrome; s1_valid=1.
- Stage 2 (output): flip bit (syndrome-1) if syndrome≠0 (all syndromes 1..N are valid positions), extract data, set flags.
- Handshake:
  - transfer on in_valid&in_ready, and on out_valid&out_ready.
  - out stage loads when !out_valid || out_ready.
  - S1 loads when !s1_valid || out stage loads.
  - in_ready = S1 load condition (combinational from out_ready; no skid buffer). Bubbles collapse.
- Latency: 2 clocks accept-to-out_valid with no backpressure; throughput 1 word/clock.
- Output hold: while out_valid=1 and out_ready=0, all out_* stay stable.
- Counters:
  - update once per output transfer.
  - corr_cnt += out_corrected; uncorr_cnt += out_uncorr.
  - saturate at 2^CNT_W-1.
  - clr_cnt has priority over a simultaneous increment (result 0).
- Without SECDED: any nonzero syndrome ⇒ out_corrected=1; out_uncorr=0. Double errors miscorrect silently.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined:
  - CW = N+1; in_code[N] = overall even parity over all N+1 bits.
  - p = XOR of all N+1 bits.
  - syn=0, p=0: clean.
  - syn≠0, p=1: correct bit syn-1; out_corrected=1.
  - syn=0, p=1: parity bit itself bad; data unchanged; out_corrected=1.
  - syn≠0, p=0: double error; out_uncorr=1, out_corrected=0; out_data = uncorrected extracted bits.
- Undefined: CW = N; no parity logic; out_uncorr tied 0; uncorr_cnt stays 0.

Test Plan:
- Clean words, R=4, SECDED off, out_ready=1: send 15'h0000 then 15'h7FFF -> out_data 11'h000 then 11'h7FF two clocks after each accept; syndrome 0; flags 0; counters 0.
- Single error on 15'h0000 with bit 4 set (position 5) -> syndrome 4'h5, out_data 11'h000, out_corrected=1, corr_cnt=1. Then 15'h7FFE (bit 0 flipped) -> syndrome 4'h1, out_data 11'h7FF, corr_cnt=2.
- SECDED on:
  - 16'h0014 (bits 2 and 4 set) -> syndrome 4'h6, out_uncorr=1, out_data 11'h003, uncorr_cnt=1.
  - 16'h8000 -> syndrome 0, out_data 0, out_corrected=1.
- Backpressure: out_ready=0, present 3 words back-to-back -> 2 accepted, then in_ready=0. out_* stable on word 1. Raise out_ready -> words emerge in order, one per clock; no loss or duplication.
- Counter saturation, CNT_W=2: 5 single-error words -> corr_cnt 1,2,3,3,3. Assert clr_cnt in the same cycle as a 6th corrected transfer -> corr_cnt=0.
- Reset mid-operation: rst_n low with both stages full -> out_valid=0 and counters 0 immediately. After release, the first output appears 2 clocks after the first new accept.

Source files
------------

// File: rtl/hamming_pipe_decoder.sv
// hamming_pipe_decoder: two-stage pipelined Hamming SEC decoder with
// valid/ready streaming and saturating error counters for PUF health checks.
// Optional macro HAMMING_SECDED_EN adds an overall parity bit (in_code[N])
// for single-error-correct / double-error-detect operation.
module hamming_pipe_decoder #(
  parameter int R     = 4,
  parameter int CNT_W = 16,
  localparam int N    = (1 << R) - 1,
  localparam int K    = N - R,
`ifdef HAMMING_SECDED_EN
  localparam int CW   = N + 1
`else
  localparam int CW   = N
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic [R-1:0]     out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // Syndrome: XOR of the 1-based positions of every set bit.
  function automatic logic [R-1:0] calc_syn(input logic [N-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (c[i]) s = s ^ R'(i + 1);
    end
    return s;
  endfunction

  // Flip the bit addressed by the syndrome when correction is enabled.
  function automatic logic [N-1:0] fix_code(input logic [N-1:0] c,
                                            input logic [R-1:0] s,
                                            input logic en);
    logic [N-1:0] f;
    f = c;
    for (int i = 0; i < N; i++) begin
      if (en && (s == R'(i + 1))) f[i] = ~c[i];
    end
    return f;
  endfunction

  // Gather non-parity positions in ascending order; the first one lands
  // in bit 0 after exactly K shifts.
  function automatic logic [K-1:0] extract_data(input logic [N-1:0] c);
    logic [K-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) d = {c[i], d[K-1:1]};
    end
    return d;
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  logic           out_load;
  logic           s1_load;
  logic           vld_p1;
  logic [N-1:0]   code_p1;
  logic [R-1:0]   syn_p1;
  logic           fix_en;
  logic           corr_p1;
  logic [K-1:0]   data_p1;
  logic           out_xfer;
`ifdef HAMMING_SECDED_EN
  logic           par_p1;
  logic           unc_p1;
  logic           uncorr_q;
  logic [CNT_W-1:0] uncorr_cnt_q;
`endif

  assign out_load = !out_valid || out_ready;
  assign s1_load  = !vld_p1 || out_load;
  assign in_ready = s1_load;
  assign out_xfer = out_valid && out_ready;

  // ---- stage 1: register accepted codeword and its syndrome ----
  // Stage-1 register: capture codeword, syndrome (and overall parity) on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      code_p1 <= '0;
      syn_p1  <= '0;
`ifdef HAMMING_SECDED_EN
      par_p1  <= 1'b0;
`endif
    end else if (s1_load) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        code_p1 <= in_code[N-1:0];
        syn_p1  <= calc_syn(in_code[N-1:0]);
`ifdef HAMMING_SECDED_EN
        par_p1  <= ^in_code;
`endif
      end
    end
  end

  // ---- stage 2: correct, extract, classify ----
  // Correction decision and data extraction from the stage-1 word.
  always_comb begin
    fix_en  = 1'b0;
    corr_p1 = 1'b0;
`ifdef HAMMING_SECDED_EN
    unc_p1  = 1'b0;
    fix_en  = par_p1 && (syn_p1 != '0);
    corr_p1 = par_p1;
    unc_p1  = !par_p1 && (syn_p1 != '0);
`else
    fix_en  = (syn_p1 != '0);
    corr_p1 = fix_en;
`endif
    data_p1 = extract_data(fix_code(code_p1, syn_p1, fix_en));
  end

  // Output register: load when empty or draining; hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
`ifdef HAMMING_SECDED_EN
      uncorr_q      <= 1'b0;
`endif
    end else if (out_load) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data      <= data_p1;
        out_syndrome  <= syn_p1;
        out_corrected <= corr_p1;
`ifdef HAMMING_SECDED_EN
        uncorr_q      <= unc_p1;
`endif
      end
    end
  end

  // Corrected-word counter: one update per output transfer, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
    end else if (out_xfer) begin
      corr_cnt <= sat_inc(corr_cnt, out_corrected);
    end
  end

`ifdef HAMMING_SECDED_EN
  // Uncorrectable-word counter: one update per output transfer, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uncorr_cnt_q <= '0;
    end else if (clr_cnt) begin
      uncorr_cnt_q <= '0;
    end else if (out_xfer) begin
      uncorr_cnt_q <= sat_inc(uncorr_cnt_q, uncorr_q);
    end
  end

  assign out_uncorr = uncorr_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  assign out_uncorr = 1'b0;
  assign uncorr_cnt = '0;
`endif

endmodule
